// File: rtl/calc_pkg.sv
// Shared types for the UART calculator controller: state codes, opcodes and
// the transmit sub-phase encoding.
package calc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_TIMEOUT   = 4'd1,
    ST_WAIT_A_HI = 4'd4,
    ST_WAIT_B_LO = 4'd5,
    ST_WAIT_B_HI = 4'd8,
    ST_WAIT_OP   = 4'd9,
    ST_EXEC      = 4'd10,
    ST_SEND      = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    PH_LO_START = 2'd0,
    PH_LO_GUARD = 2'd1,
    PH_HI_START = 2'd2,
    PH_HI_DONE  = 2'd3
  } send_phase_e;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;

  // States in which the inter-byte timeout counter runs.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_WAIT_A_HI) || (s == ST_WAIT_B_LO) ||
           (s == ST_WAIT_B_HI) || (s == ST_WAIT_OP);
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational calculator ALU; operands are zero-extended to 17 bits so
// bit 16 carries the add carry or subtract borrow.
module calc_alu
  import calc_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [7:0]  op_i,
  output logic [16:0] res_o,
  output logic        err_o
);

  // Opcode decode and arithmetic.
  always_comb begin
    res_o = 17'h00000;
    err_o = 1'b0;
    case (op_i)
      OP_ADD:  res_o = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  res_o = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  res_o = {1'b0, a_i & b_i};
      OP_OR:   res_o = {1'b0, a_i | b_i};
      OP_XOR:  res_o = {1'b0, a_i ^ b_i};
      default: begin
        res_o = 17'h00000;
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_calc_ctrl.sv
// UART calculator sequencer: gathers A, B and opcode bytes, runs the ALU and
// returns the result low byte first over the transmitter handshake.
module uart_calc_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [3:0]  state,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [16:0] res,
  output logic        op_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  send_phase_e       phase_q, phase_d;
  logic [15:0]       a_q, a_d;
  logic [15:0]       b_q, b_d;
  logic [7:0]        op_q, op_d;
  logic [16:0]       res_q, res_d;
  logic              op_err_q, op_err_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cnt_last_s;
  logic [16:0]       alu_res_s;
  logic              alu_err_s;

  calc_alu u_alu (
    .a_i   (a_q),
    .b_i   (b_q),
    .op_i  (op_q),
    .res_o (alu_res_s),
    .err_o (alu_err_s)
  );

  // The counter only advances while parked in a wait state; any byte or
  // state change (including the expiry itself) returns it to zero.
  assign cnt_last_s = (cnt_q == CNT_LAST);
  assign cnt_d = (is_wait_state(state_q) && !rx_ready && !cnt_last_s) ?
                 (cnt_q + CNT_W'(1)) : {CNT_W{1'b0}};

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    op_err_d   = op_err_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_ready) begin
          a_d     = {8'h00, rx_data};
          b_d     = 16'h0000;
          op_d    = 8'h00;
          state_d = ST_WAIT_A_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_A_HI: begin
        if (rx_ready) begin
          a_d[15:8] = rx_data;
          state_d   = ST_WAIT_B_LO;
        end else if (cnt_last_s) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_WAIT_A_HI;
        end
      end
      ST_WAIT_B_LO: begin
        if (rx_ready) begin
          b_d[7:0] = rx_data;
          state_d  = ST_WAIT_B_HI;
        end else if (cnt_last_s) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_WAIT_B_LO;
        end
      end
      ST_WAIT_B_HI: begin
        if (rx_ready) begin
          b_d[15:8] = rx_data;
          state_d   = ST_WAIT_OP;
        end else if (cnt_last_s) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_WAIT_B_HI;
        end
      end
      ST_WAIT_OP: begin
        if (rx_ready) begin
          op_d    = rx_data;
          state_d = ST_EXEC;
        end else if (cnt_last_s) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_WAIT_OP;
        end
      end
      ST_EXEC: begin
        res_d    = alu_res_s;
        op_err_d = alu_err_s;
        phase_d  = PH_LO_START;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        // tx_start_q is high exactly during each guard cycle, which gives the
        // transmitter one cycle to raise busy before it is looked at again.
        case (phase_q)
          PH_LO_START: begin
            if (!tx_busy) begin
              tx_start_d = 1'b1;
              tx_data_d  = res_q[7:0];
              phase_d    = PH_LO_GUARD;
            end else begin
              phase_d = PH_LO_START;
            end
          end
          PH_LO_GUARD: phase_d = PH_HI_START;
          PH_HI_START: begin
            if (!tx_busy) begin
              tx_start_d = 1'b1;
              tx_data_d  = res_q[15:8];
              phase_d    = PH_HI_DONE;
            end else begin
              phase_d = PH_HI_START;
            end
          end
          PH_HI_DONE: begin
            if (!tx_start_q && !tx_busy) begin
              phase_d = PH_LO_START;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_SEND;
            end
          end
          default: phase_d = PH_LO_START;
        endcase
      end
      ST_TIMEOUT: begin
        a_d     = 16'h0000;
        b_d     = 16'h0000;
        op_d    = 8'h00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_LO_START;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      op_q       <= 8'h00;
      res_q      <= 17'h00000;
      op_err_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      op_err_q   <= op_err_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign state    = state_q;
  assign a        = a_q;
  assign b        = b_q;
  assign res      = res_q;
  assign op_err   = op_err_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_calc_ctrl.sv
// Scoreboard bench for uart_calc_ctrl: stimulus pushes expected TX bytes,
// an independent monitor pops and compares them on every tx_start.
module tb_uart_calc_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  state;
  logic [15:0] a;
  logic [15:0] b;
  logic [16:0] res;
  logic        op_err;

  logic        model_busy;
  logic        hold_busy;
  int          n_total;
  int          n_pass;
  logic [7:0]  exp_q[$];
  int          last_res;

  assign tx_busy = model_busy | hold_busy;

  uart_calc_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .state    (state),
    .a        (a),
    .b        (b),
    .res      (res),
    .op_err   (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference calculator straight from the opcode table.
  function automatic int ref_res(input int av, input int bv, input int opv);
    case (opv)
      0: return av + bv;
      1: return (av + 131072 - bv) % 131072;
      2: return av & bv;
      3: return av | bv;
      4: return av ^ bv;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_err(input int opv);
    return (opv > 4) ? 1 : 0;
  endfunction

  // Transmitter model: raises busy right after seeing a start pulse.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (tx_start === 1'b1) begin
        model_busy = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        #1;
        model_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every start pulse.
  initial begin
    logic prev_start;
    logic [7:0] e;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        check("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
        check("tx_start_back_to_back", {31'd0, prev_start}, 32'd0);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL tx_unexpected: got byte 0x%0h, expected no transmission", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", {24'd0, tx_data}, {24'd0, e});
        end
      end
      prev_start = tx_start;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic [3:0] exp_state, input int gap);
    repeat (gap) @(negedge clk);
    rx_data  = d;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("state_after_byte", {28'd0, state}, {28'd0, exp_state});
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (state !== 4'd0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("return_to_idle", {28'd0, state}, 32'd0);
  endtask

  // Sends B and opcode after A is in place, then checks the EXEC outcome.
  task automatic issue_rest(input int av, input int bv, input int opv);
    int r;
    r = ref_res(av, bv, opv);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
    send_byte(bv[7:0], 4'd8, $urandom_range(0, 2));
    send_byte(bv[15:8], 4'd9, $urandom_range(0, 2));
    send_byte(opv[7:0], 4'd10, $urandom_range(0, 2));
    @(negedge clk);
    check("state_send", {28'd0, state}, 32'd11);
    check("no_early_tx_start", {31'd0, tx_start}, 32'd0);
    check("res", {15'd0, res}, r);
    check("op_err", {31'd0, op_err}, ref_err(opv));
    check("a_reg", {16'd0, a}, av);
    check("b_reg", {16'd0, b}, bv);
    last_res = r;
  endtask

  task automatic issue_txn(input int av, input int bv, input int opv);
    send_byte(av[7:0], 4'd4, $urandom_range(0, 2));
    send_byte(av[15:8], 4'd5, $urandom_range(0, 2));
    issue_rest(av, bv, opv);
  endtask

  initial begin
    int busy_starts;
    int n;
    reset     = 1'b1;
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    hold_busy = 1'b0;
    n_total   = 0;
    n_pass    = 0;
    last_res  = 0;
    repeat (3) @(negedge clk);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_a", {16'd0, a}, 32'd0);
    check("rst_b", {16'd0, b}, 32'd0);
    check("rst_res", {15'd0, res}, 32'd0);
    check("rst_op_err", {31'd0, op_err}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases including carry and borrow.
    issue_txn(32'h1234, 32'h0F0F, 0); wait_idle(100);
    issue_txn(32'h0001, 32'h0002, 1); wait_idle(100);
    issue_txn(32'hFFFF, 32'h0001, 0); wait_idle(100);
    issue_txn(32'hA5A5, 32'h0FF0, 7); wait_idle(100);
    issue_txn(32'hA5A5, 32'h0FF0, 2); wait_idle(100);

    // Randomized operands, mostly valid opcodes.
    for (int i = 0; i < 16; i++) begin
      int opv;
      opv = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 255);
      issue_txn($urandom_range(0, 65535), $urandom_range(0, 65535), opv);
      wait_idle(100);
    end

    // Timeout after a single byte: res survives, operands are cleared.
    send_byte(8'h34, 4'd4, 0);
    repeat (15) @(negedge clk);
    check("timeout_not_early", {28'd0, state}, 32'd4);
    @(negedge clk);
    check("timeout_state", {28'd0, state}, 32'd1);
    @(negedge clk);
    check("timeout_back_idle", {28'd0, state}, 32'd0);
    check("timeout_a_cleared", {16'd0, a}, 32'd0);
    check("timeout_res_kept", {15'd0, res}, last_res);

    // A byte arriving in the expiry cycle is captured instead.
    send_byte(8'h56, 4'd4, 0);
    repeat (15) @(negedge clk);
    send_byte(8'h9A, 4'd5, 0);
    issue_rest(32'h9A56, 32'h1111, 3);
    wait_idle(100);

    // Transmitter held busy: no start, and a stray byte during SEND is dropped.
    hold_busy = 1'b1;
    issue_txn(32'h0102, 32'h0304, 4);
    busy_starts = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        rx_data  = 8'hEE;
        rx_ready = 1'b1;
      end else begin
        rx_ready = 1'b0;
      end
      @(negedge clk);
      if (tx_start === 1'b1) busy_starts++;
    end
    rx_ready = 1'b0;
    check("no_start_while_held", busy_starts, 32'd0);
    check("held_in_send", {28'd0, state}, 32'd11);
    hold_busy = 1'b0;
    wait_idle(100);
    check("stray_byte_a", {16'd0, a}, 32'h0102);
    check("stray_byte_b", {16'd0, b}, 32'h0304);

    // Reset between the two result bytes.
    issue_txn(32'hBEEF, 32'h1234, 0);
    n = 0;
    while (tx_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("first_byte_seen", {31'd0, tx_start}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midsend_rst_state", {28'd0, state}, 32'd0);
    check("midsend_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("midsend_rst_a", {16'd0, a}, 32'd0);
    check("midsend_rst_b", {16'd0, b}, 32'd0);
    check("midsend_rst_res", {15'd0, res}, 32'd0);
    check("midsend_rst_op_err", {31'd0, op_err}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_idle", {28'd0, state}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
